// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions used by the fetch stage and reused by decode.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    // Instruction addresses are always word aligned; low two bits are forced to zero.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if_buf_reg.sv
// One-entry IF/ID output buffer: holds a fetched instruction until ID accepts it.
module if_buf_reg
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic            accept,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;

    assign accept = valid_q & ~stall;

    // Flush beats a new load, and a new load beats the consume of the old entry.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            inst_d  = load_inst;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign inst  = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs a single-outstanding ROM
// handshake and feeds ID through a one-entry buffer.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_addr,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fetch_err,
    output logic        busy
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 2);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_err_q, fetch_err_d;

    logic             accept;
    logic             issue;
    logic             buf_load;
    logic [XLEN-1:0]  buf_load_pc;
    logic [XLEN-1:0]  branch_tgt;

    assign branch_tgt = align_word(branch_addr);

    // A new request only goes out when the buffer will have room for its data.
    assign issue = (state_q == ISSUE) & go & ~branch & ~fetch_err_q & (~if_valid | accept);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
        buf_load    = 1'b0;
        buf_load_pc = pc_q;

        if (branch) begin
            pc_d = branch_tgt;
        end

        case (state_q)
            ISSUE: begin
                if (issue) begin
                    addr_d = pc_q;
                    pc_d   = pc_q + XLEN'(4);
                    if (rom_ack) begin
                        buf_load    = 1'b1;
                        buf_load_pc = pc_q;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                if (rom_ack) begin
                    // Data for a stale PC is dropped, whether the redirect came earlier or now.
                    state_d     = ISSUE;
                    cnt_d       = '0;
                    discard_d   = 1'b0;
                    buf_load    = ~discard_q & ~branch;
                    buf_load_pc = addr_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ISSUE;
                    cnt_d       = '0;
                    discard_d   = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (branch) begin
                        discard_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ISSUE;
            pc_q        <= RESET_PC;
            addr_q      <= '0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    if_buf_reg u_if_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush     (branch),
        .load      (buf_load),
        .load_pc   (buf_load_pc),
        .load_inst (rom_data),
        .accept    (accept),
        .valid     (if_valid),
        .pc        (if_pc),
        .inst      (if_inst)
    );

    // Request is gated by reset so nothing leaks to the ROM while the core is held.
    assign rom_req   = reset_n & (issue | (state_q == WAIT));
    assign rom_addr  = (state_q == WAIT) ? addr_q : pc_q;
    assign busy      = (state_q == WAIT);
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a scriptable ROM responder.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        go;
    logic        stall;
    logic        branch;
    logic [31:0] branch_addr;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_err;
    logic        busy;

    logic        zw_mode;
    logic        man_ack;
    logic [31:0] man_data;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .stall       (stall),
        .branch      (branch),
        .branch_addr (branch_addr),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .fetch_err   (fetch_err),
        .busy        (busy)
    );

    // Zero-wait mode acks in the request cycle with data derived from the address.
    assign rom_ack  = zw_mode ? rom_req : man_ack;
    assign rom_data = zw_mode ? (rom_addr ^ 32'hA5A5_0000) : man_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        go          = 1'b0;
        stall       = 1'b0;
        branch      = 1'b0;
        branch_addr = 32'h0;
        zw_mode     = 1'b0;
        man_ack     = 1'b0;
        man_data    = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; go = 1'b0; stall = 1'b0; branch = 1'b0; branch_addr = 32'h0;
        zw_mode = 1'b0; man_ack = 1'b0; man_data = 32'h0;
        #1;
        reset_n = 1'b0;
        go = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", rom_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h expected 0", if_pc); end
        checks++; if (if_inst !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst: got %h expected 0", if_inst); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", fetch_err); end
        go = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait();
        do_reset();
        zw_mode = 1'b1;
        go = 1'b1;
        #1;
        checks++; if (rom_req !== 1'b1) begin errors++; $display("[TB] FAIL zw_req0: got %b expected 1", rom_req); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL zw_addr0: got %h expected 0", rom_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_valid0: got %b expected 0", if_valid); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            #1;
            checks++; if (rom_addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL zw_addr: got %h expected %h", rom_addr, 32'(4 * k)); end
            checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL zw_valid: got %b expected 1", if_valid); end
            checks++; if (if_pc !== 32'(4 * (k - 1))) begin errors++; $display("[TB] FAIL zw_pc: got %h expected %h", if_pc, 32'(4 * (k - 1))); end
            checks++; if (if_inst !== (32'(4 * (k - 1)) ^ 32'hA5A5_0000)) begin errors++; $display("[TB] FAIL zw_inst: got %h expected %h", if_inst, 32'(4 * (k - 1)) ^ 32'hA5A5_0000); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        zw_mode = 1'b1;
        go = 1'b1;
        tick();
        tick();
        tick();
        stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            #1;
            checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL st_valid: got %b expected 1", if_valid); end
            checks++; if (if_pc !== 32'h8) begin errors++; $display("[TB] FAIL st_pc: got %h expected 8", if_pc); end
            checks++; if (if_inst !== 32'hA5A5_0008) begin errors++; $display("[TB] FAIL st_inst: got %h expected a5a50008", if_inst); end
            checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL st_req: got %b expected 0", rom_req); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (rom_req !== 1'b1) begin errors++; $display("[TB] FAIL st_resume_req: got %b expected 1", rom_req); end
        checks++; if (rom_addr !== 32'hC) begin errors++; $display("[TB] FAIL st_resume_addr: got %h expected c", rom_addr); end
        tick();
        #1;
        checks++; if (if_pc !== 32'hC) begin errors++; $display("[TB] FAIL st_next_pc: got %h expected c", if_pc); end
    endtask

    task automatic test_wait_ack();
        do_reset();
        go = 1'b1;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wa_r0: got req=%b addr=%h busy=%b expected 1/0/0", rom_req, rom_addr, busy); end
        tick();
        stall = 1'b1;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wa_r1: got req=%b addr=%h busy=%b expected 1/0/1", rom_req, rom_addr, busy); end
        tick();
        stall = 1'b0;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL wa_r2: got req=%b addr=%h valid=%b expected 1/0/0", rom_req, rom_addr, if_valid); end
        tick();
        man_ack = 1'b1;
        man_data = 32'h1234_5678;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL wa_r3: got req=%b addr=%h expected 1/0", rom_req, rom_addr); end
        tick();
        man_ack = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("[TB] FAIL wa_cap: got valid=%b pc=%h expected 1/0", if_valid, if_pc); end
        checks++; if (if_inst !== 32'h1234_5678) begin errors++; $display("[TB] FAIL wa_inst: got %h expected 12345678", if_inst); end
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h4 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wa_next: got req=%b addr=%h busy=%b expected 1/4/0", rom_req, rom_addr, busy); end
    endtask

    task automatic test_branch_discard();
        do_reset();
        go = 1'b1;
        branch = 1'b1;
        branch_addr = 32'h0000_0010;
        #1;
        checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL bd_noissue: got %b expected 0", rom_req); end
        tick();
        branch = 1'b0;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h10) begin errors++; $display("[TB] FAIL bd_req: got req=%b addr=%h expected 1/10", rom_req, rom_addr); end
        tick();
        branch = 1'b1;
        branch_addr = 32'h0000_0103;
        #1;
        checks++; if (rom_addr !== 32'h10 || busy !== 1'b1) begin errors++; $display("[TB] FAIL bd_hold: got addr=%h busy=%b expected 10/1", rom_addr, busy); end
        tick();
        branch = 1'b0;
        #1;
        checks++; if (rom_addr !== 32'h10 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL bd_hold2: got addr=%h valid=%b expected 10/0", rom_addr, if_valid); end
        tick();
        man_ack = 1'b1;
        man_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h10) begin errors++; $display("[TB] FAIL bd_ack: got req=%b addr=%h expected 1/10", rom_req, rom_addr); end
        tick();
        man_ack = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL bd_dropvalid: got %b expected 0", if_valid); end
        checks++; if (if_inst === 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL bd_dropinst: got %h expected not deadbeef", if_inst); end
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h100 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bd_target: got req=%b addr=%h busy=%b expected 1/100/0", rom_req, rom_addr, busy); end
        man_ack = 1'b1;
        man_data = 32'h0BAD_F00D;
        tick();
        man_ack = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL bd_cap: got valid=%b pc=%h inst=%h expected 1/100/0badf00d", if_valid, if_pc, if_inst); end
    endtask

    task automatic test_branch_ack_same();
        do_reset();
        go = 1'b1;
        branch = 1'b1;
        branch_addr = 32'h0000_0020;
        tick();
        branch = 1'b0;
        man_ack = 1'b1;
        man_data = 32'h1111_1111;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h20) begin errors++; $display("[TB] FAIL ba_req: got req=%b addr=%h expected 1/20", rom_req, rom_addr); end
        tick();
        man_ack = 1'b0;
        stall = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h20 || rom_req !== 1'b0) begin errors++; $display("[TB] FAIL ba_held: got valid=%b pc=%h req=%b expected 1/20/0", if_valid, if_pc, rom_req); end
        tick();
        branch = 1'b1;
        branch_addr = 32'h0000_0200;
        man_ack = 1'b1;
        man_data = 32'h2222_2222;
        #1;
        checks++; if (rom_req !== 1'b0) begin errors++; $display("[TB] FAIL ba_brreq: got %b expected 0", rom_req); end
        tick();
        branch = 1'b0;
        man_ack = 1'b0;
        stall = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || if_inst === 32'h2222_2222) begin errors++; $display("[TB] FAIL ba_flush: got valid=%b inst=%h expected 0/not 22222222", if_valid, if_inst); end
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h200) begin errors++; $display("[TB] FAIL ba_target: got req=%b addr=%h expected 1/200", rom_req, rom_addr); end
        tick();
        branch = 1'b1;
        branch_addr = 32'h0000_0300;
        man_ack = 1'b1;
        man_data = 32'h3333_3333;
        #1;
        checks++; if (busy !== 1'b1 || rom_addr !== 32'h200) begin errors++; $display("[TB] FAIL ba_wait: got busy=%b addr=%h expected 1/200", busy, rom_addr); end
        tick();
        branch = 1'b0;
        man_ack = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ba_wdrop: got valid=%b busy=%b expected 0/0", if_valid, busy); end
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h300) begin errors++; $display("[TB] FAIL ba_wtarget: got req=%b addr=%h expected 1/300", rom_req, rom_addr); end
        man_ack = 1'b1;
        man_data = 32'h4444_4444;
        tick();
        man_ack = 1'b0;
        branch = 1'b1;
        branch_addr = 32'h0000_0400;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_inst !== 32'h4444_4444) begin errors++; $display("[TB] FAIL ba_cap: got valid=%b pc=%h inst=%h expected 1/300/44444444", if_valid, if_pc, if_inst); end
        tick();
        branch_addr = 32'h0000_0500;
        #1;
        checks++; if (if_valid !== 1'b0 || rom_req !== 1'b0) begin errors++; $display("[TB] FAIL ba_b2b: got valid=%b req=%b expected 0/0", if_valid, rom_req); end
        tick();
        branch = 1'b0;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h500) begin errors++; $display("[TB] FAIL ba_last: got req=%b addr=%h expected 1/500", rom_req, rom_addr); end
    endtask

    task automatic test_timeout();
        int  n;
        bit  done;
        do_reset();
        go = 1'b1;
        #1;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (fetch_err === 1'b1) begin
                done = 1'b1;
            end else begin
                if (rom_req === 1'b1) n++;
                @(posedge clk);
                #2;
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL to_bound: got no fetch_err within 40 cycles, expected fetch_err"); end
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL to_reqcycles: got %0d expected 16", n); end
        for (int j = 0; j < 5; j++) begin
            checks++; if (rom_req !== 1'b0 || fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL to_blocked: got req=%b err=%b expected 0/1", rom_req, fetch_err); end
            @(posedge clk);
            #2;
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (fetch_err !== 1'b0 || rom_req !== 1'b0 || busy !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_async: got err=%b req=%b busy=%b valid=%b expected 0/0/0/0", fetch_err, rom_req, busy, if_valid); end
        #2;
        reset_n = 1'b1;
        #1;
        checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL to_resume: got req=%b addr=%h expected 1/0", rom_req, rom_addr); end
        tick();
        #1;
        checks++; if (busy !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL to_wait: got busy=%b addr=%h expected 1/0", busy, rom_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait_ack();
        test_branch_discard();
        test_branch_ack_same();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
